// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the LEGv8 data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 8;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - datapath DM port bundle; master is the datapath, slave is the responder
interface dmem_if #(
  parameter int N = 64
);

  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] DM_readData;
  logic         stall;
  logic         err;

  modport master (
    output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
    input  DM_readData, stall, err
  );

  modport slave (
    input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
    output DM_readData, stall, err
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 2^AW x N storage, synchronous write, asynchronous read
module dmem_array #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle DM responder with stall; DMEM_ERR_EN adds misalign/range error checking
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N   = 64,
  parameter int AW  = 6,
  parameter int LAT = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int OFS_W = $clog2(WORD_BYTES);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    idxQ;
  logic [N-1:0]     dataQ;
  logic [N-1:0]     readDataQ;
  logic             isWrite;
  logic             badQ;

  logic             request;
  logic             addrBad;
  logic             commit;
  logic             memWe;
  logic             stallC;
  logic [N-1:0]     memRdata;

  assign request = bus.DM_readEnable | bus.DM_writeEnable;

`ifdef DMEM_ERR_EN
  assign addrBad = (bus.DM_addr[OFS_W-1:0] != '0) || (bus.DM_addr[N-1:AW+OFS_W] != '0);
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.DM_addr[N-1:AW+OFS_W], bus.DM_addr[OFS_W-1:0]};
  assign addrBad = 1'b0;
`endif

  // Gating with reset makes a reset during the final wait cycle discard the write.
  assign commit = (state == S_BUSY) && (cnt == '0) && !reset;
  assign memWe  = commit && isWrite && !badQ;

  dmem_array #(
    .N  (N),
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .we    (memWe),
    .waddr (idxQ),
    .wdata (dataQ),
    .raddr (idxQ),
    .rdata (memRdata)
  );

  always_comb begin
    stallC = 1'b0;
    case (state)
      S_IDLE:  stallC = request;
      S_BUSY:  stallC = 1'b1;
      default: stallC = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      readDataQ <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            idxQ    <= bus.DM_addr[AW+OFS_W-1:OFS_W];
            dataQ   <= bus.DM_writeData;
            isWrite <= bus.DM_writeEnable;
            badQ    <= addrBad;
            cnt     <= CNT_INIT;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_RESP;
            if (!isWrite) begin
              readDataQ <= badQ ? '0 : memRdata;
            end
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_ERR_EN
  logic errQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      errQ <= 1'b0;
    end else if (commit) begin
      errQ <= badQ;
    end else if (state == S_RESP) begin
      errQ <= 1'b0;
    end
  end

  assign bus.err = errQ;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.stall       = stallC;
  assign bus.DM_readData = readDataQ;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed-vector bench for dmem_responder at LAT=2, 1 and 15
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  int   vecCount  = 0;
  int   missCount = 0;
  int   commitCount = 0;

  always #5 clk = ~clk;

  dmem_if #(.N(64)) bus2 ();
  dmem_if #(.N(64)) bus1 ();
  dmem_if #(.N(64)) bus15 ();

  dmem_responder #(.N(64), .AW(6), .LAT(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2));
  dmem_responder #(.N(64), .AW(6), .LAT(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.N(64), .AW(6), .LAT(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15));

  always @(posedge clk) begin
    if (!reset && dut2.state == 2'd1 && dut2.cnt == 4'd0) commitCount++;
  end

  task automatic checkVec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveReq(input int sel, input logic [63:0] a, input logic [63:0] d,
                          input logic we, input logic re);
    case (sel)
      1: begin
        bus1.DM_addr = a; bus1.DM_writeData = d; bus1.DM_writeEnable = we; bus1.DM_readEnable = re;
      end
      15: begin
        bus15.DM_addr = a; bus15.DM_writeData = d; bus15.DM_writeEnable = we; bus15.DM_readEnable = re;
      end
      default: begin
        bus2.DM_addr = a; bus2.DM_writeData = d; bus2.DM_writeEnable = we; bus2.DM_readEnable = re;
      end
    endcase
  endtask

  function automatic logic stallOf(input int sel);
    case (sel)
      1:       return bus1.stall;
      15:      return bus15.stall;
      default: return bus2.stall;
    endcase
  endfunction

  // Issues a request at a negedge, counts stall-high cycles; returns sitting in the RESP cycle.
  task automatic doAccess(input int sel, input logic [63:0] a, input logic [63:0] d,
                          input logic we, input logic re, input logic holdInResp, output int n);
    @(negedge clk);
    driveReq(sel, a, d, we, re);
    #1;
    n = 0;
    while (stallOf(sel) && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (!holdInResp) driveReq(sel, 64'h0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] expWrap;
    logic        expErr;

    reset = 1'b1;
    driveReq(2, 64'h0, 64'h0, 1'b0, 1'b0);
    driveReq(1, 64'h0, 64'h0, 1'b0, 1'b0);
    driveReq(15, 64'h0, 64'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkVec("reset_stall", {63'h0, bus2.stall}, 64'h0);
    checkVec("reset_rdata", bus2.DM_readData, 64'h0);
    checkVec("reset_err", {63'h0, bus2.err}, 64'h0);

    doAccess(2, 64'h10, 64'hDEADBEEF, 1'b1, 1'b0, 1'b0, n);
    checkVec("wr_stall_cycles", n, 3);
    doAccess(2, 64'h10, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("rd_stall_cycles", n, 3);
    checkVec("rd_data", bus2.DM_readData, 64'hDEADBEEF);

    doAccess(2, 64'h0, 64'h11, 1'b1, 1'b0, 1'b0, n);
    doAccess(2, 64'h200, 64'h5, 1'b1, 1'b0, 1'b0, n);
`ifdef DMEM_ERR_EN
    expErr  = 1'b1;
    expWrap = 64'h11;
`else
    expErr  = 1'b0;
    expWrap = 64'h5;
`endif
    checkVec("wrap_err_resp", {63'h0, bus2.err}, {63'h0, expErr});
    @(negedge clk);
    #1;
    checkVec("wrap_err_clear", {63'h0, bus2.err}, 64'h0);
    doAccess(2, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("wrap_rd_data", bus2.DM_readData, expWrap);

    doAccess(2, 64'h8, 64'h7, 1'b1, 1'b1, 1'b0, n);
    checkVec("both_en_stall", n, 3);
    checkVec("both_en_rdata_hold", bus2.DM_readData, expWrap);
    doAccess(2, 64'h8, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("both_en_mem", bus2.DM_readData, 64'h7);

    commitCount = 0;
    doAccess(2, 64'h10, 64'h0, 1'b0, 1'b1, 1'b1, n);
    checkVec("b2b_first_data", bus2.DM_readData, 64'hDEADBEEF);
    doAccess(2, 64'h8, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("b2b_second_stall", n, 3);
    checkVec("b2b_second_data", bus2.DM_readData, 64'h7);
    checkVec("b2b_commits", commitCount, 2);

    doAccess(2, 64'h18, 64'h0, 1'b1, 1'b0, 1'b0, n);
    @(negedge clk);
    driveReq(2, 64'h18, 64'h9, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    driveReq(2, 64'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVec("rst_busy_stall", {63'h0, bus2.stall}, 64'h0);
    checkVec("rst_busy_rdata", bus2.DM_readData, 64'h0);
    checkVec("rst_busy_state", {62'h0, dut2.state}, 64'h0);
    doAccess(2, 64'h18, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("rst_busy_discard", bus2.DM_readData, 64'h0);

    doAccess(1, 64'h8, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("lat1_stall_cycles", n, 2);
    doAccess(15, 64'h8, 64'h0, 1'b0, 1'b1, 1'b0, n);
    checkVec("lat15_stall_cycles", n, 16);
    @(negedge clk);
    #1;
    checkVec("lat15_idle_stall", {63'h0, bus15.stall}, 64'h0);
    @(negedge clk);
    #1;
    checkVec("lat15_idle_state", {62'h0, dut15.state}, 64'h0);
    checkVec("lat15_idle_cnt", {60'h0, dut15.cnt}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
